bcd_time_load: RTL and testbench
================================

BCD_TIME_LOAD -- requirements
Module: bcd_time_load

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000, number of idle cycles between digits that aborts an entry in progress.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_  input  1  asynchronous, active-low reset.
REQ-004 dig_valid  input  1  dig_in carries a digit this cycle.
REQ-005 dig_in  input  4  BCD digit, entered in the order hour-tens, hour-units, minute-tens, minute-units.
REQ-006 abort  input  1  synchronous cancel of the entry in progress.
REQ-007 dig_ready  output  1  block accepts a digit this cycle.
REQ-008 digit_idx  output  2  index of the next expected digit, 0..3.
REQ-009 busy  output  1  high from the first accepted digit until load_pulse or error.
REQ-010 hour_bin  output  5  last loaded hour, in binary.
REQ-011 min_bin  output  6  last loaded minute, in binary.
REQ-012 load_pulse  output  1  one-cycle strobe; hour_bin and min_bin carry new values.
REQ-013 err_pulse  output  1  one-cycle strobe on a rejected digit or a timeout.

Function
REQ-014 The FSM states SHALL be S_H1, S_H0, S_M1, S_M0, S_CONV_H, S_CONV_M, S_DONE.
REQ-015 A digit SHALL be accepted only in a cycle where dig_valid and dig_ready are both high; dig_ready SHALL be high only in S_H1..S_M0.
REQ-016 digit_idx SHALL be 0/1/2/3 in S_H1/S_H0/S_M1/S_M0 and 0 in every other state.
REQ-017 Each accepted digit SHALL be stored and the FSM SHALL advance one state: S_H1->S_H0->S_M1->S_M0->S_CONV_H.
REQ-018 A digit SHALL be rejected (err_pulse the next cycle, all stored digits cleared, FSM to S_H1) under any of these conditions:
- any digit greater than 9;
- hour-tens greater than 2;
- hour-tens equal to 2 and hour-units greater than 3;
- minute-tens greater than 5.
REQ-019 S_CONV_H SHALL compute hour = ht*8 + ht*2 + hu, and S_CONV_M SHALL compute minute = mt*8 + mt*2 + mu, in 6-bit arithmetic with no overflow possible.
REQ-020 In S_DONE the block SHALL:
- register hour_bin and min_bin;
- assert load_pulse for exactly one cycle;
- return to S_H1.
REQ-021 Latency: with the minute-units digit accepted at edge N, load_pulse SHALL be high in the cycle after edge N+3.
REQ-022 hour_bin and min_bin SHALL hold their values between loads and SHALL NOT change on an error, abort or timeout.
REQ-023 The timeout counter SHALL clear on every accepted digit and count only in S_H0..S_M0; reaching TIMEOUT_CYC-1 SHALL cause err_pulse, clear the stored digits and send the FSM to S_H1.
REQ-024 abort SHALL send the FSM to S_H1 from any state and clear the stored digits with no err_pulse; it SHALL have priority over a digit accepted in the same cycle and over the timeout.
REQ-025 An abort during S_CONV_H, S_CONV_M or S_DONE SHALL suppress load_pulse and leave the outputs unchanged.
REQ-026 busy SHALL be low in S_H1 and high in every other state.

Reset
REQ-027 While reset_ is low:
- FSM in S_H1;
- stored digits and timeout counter cleared;
- hour_bin=0, min_bin=0;
- load_pulse=0, err_pulse=0, busy=0;
- dig_ready=1, digit_idx=0.

Configuration
REQ-028 With HOUR12_EN defined, the valid hours SHALL be 01..12: hour-tens greater than 1, hour-tens 1 with hour-units greater than 2, and hour 00 SHALL all be rejected.
REQ-029 Without HOUR12_EN, the valid hours SHALL be 00..23 as in REQ-018; the minute rules are unchanged in both builds.

Structure
REQ-030 Package bcd_time_pkg SHALL hold:
- the FSM state typedef;
- MAX_HOUR_TENS, MAX_MIN_TENS, MAX_BCD;
- the 12/24-hour limits.
REQ-031 The multiply-by-ten shift-add datapath SHALL be sub-module bcd2bin_mul10 (inputs tens and units, output 7-bit binary), instantiated once and shared by the two conversion states.

Verification
REQ-032 Digits 2,3,5,9 with back-to-back valid -> load_pulse 3 cycles after the last accept, hour_bin=23, min_bin=59.
REQ-033 Digits 2,4 -> err_pulse after the second digit, digit_idx=0, hour_bin/min_bin unchanged; then 0,7,0,5 -> hour_bin=7, min_bin=5.
REQ-034 Digits 1,2,6 -> err_pulse on the minute-tens digit; digit 0xA as the first digit -> err_pulse.
REQ-035 Digits 1,0 followed by TIMEOUT_CYC idle cycles -> one err_pulse, FSM back in S_H1, no load_pulse.
REQ-036 Abort asserted in the same cycle as the minute-units digit, and abort asserted during S_CONV_M -> no load_pulse, no err_pulse, outputs unchanged.
REQ-037 HOUR12_EN build: digits 0,0,1,0 -> err_pulse; digits 1,2,0,0 -> hour_bin=12, min_bin=0.

Source files
------------

// File: rtl/bcd_time_pkg.sv
// Shared types and digit limits for the BCD time loader.
// Define HOUR12_EN to accept 12-hour times (01..12) instead of 24-hour times (00..23).
package bcd_time_pkg;

  typedef enum logic [2:0] {
    S_H1,
    S_H0,
    S_M1,
    S_M0,
    S_CONV_H,
    S_CONV_M,
    S_DONE
  } state_t;

  localparam logic [3:0] MAX_BCD      = 4'd9;
  localparam logic [3:0] MAX_MIN_TENS = 4'd5;

  // Largest hour-tens digit, and the largest hour-units digit allowed when the tens digit is at max
  localparam logic [3:0] H24_MAX_TENS      = 4'd2;
  localparam logic [3:0] H24_MAX_UNITS_TOP = 4'd3;
  localparam logic [3:0] H12_MAX_TENS      = 4'd1;
  localparam logic [3:0] H12_MAX_UNITS_TOP = 4'd2;

`ifdef HOUR12_EN
  localparam bit HOUR12 = 1'b1;
`else
  localparam bit HOUR12 = 1'b0;
`endif

  localparam logic [3:0] MAX_HOUR_TENS      = HOUR12 ? H12_MAX_TENS : H24_MAX_TENS;
  localparam logic [3:0] MAX_HOUR_UNITS_TOP = HOUR12 ? H12_MAX_UNITS_TOP : H24_MAX_UNITS_TOP;

endpackage

// File: rtl/bcd2bin_mul10.sv
// Two-digit BCD to binary: tens*8 + tens*2 + units.
module bcd2bin_mul10 (
  input  logic [3:0] tens,
  input  logic [3:0] units,
  output logic [6:0] bin
);

  assign bin = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, units};

endmodule

// File: rtl/bcd_time_load.sv
// Collects four BCD digits (hh:mm), validates them, converts to binary and loads hour/minute.
// Build option: HOUR12_EN selects 12-hour validation (see bcd_time_pkg).
module bcd_time_load
  import bcd_time_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       dig_valid,
  input  logic [3:0] dig_in,
  input  logic       abort,
  output logic       dig_ready,
  output logic [1:0] digit_idx,
  output logic       busy,
  output logic [4:0] hour_bin,
  output logic [5:0] min_bin,
  output logic       load_pulse,
  output logic       err_pulse
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t           state;
  logic [3:0]       ht, hu, mt, mu;
  logic [4:0]       hour_q;
  logic [5:0]       min_q;
  logic [TMO_W-1:0] tmo;
  logic             accept;
  logic             dig_bad;
  logic [3:0]       conv_tens, conv_units;
  logic [6:0]       conv_bin;
  logic             unused_conv_msb;

  always_comb begin
    dig_ready = 1'b0;
    digit_idx = 2'd0;
    unique case (state)
      S_H1:    dig_ready = 1'b1;
      S_H0:    begin dig_ready = 1'b1; digit_idx = 2'd1; end
      S_M1:    begin dig_ready = 1'b1; digit_idx = 2'd2; end
      S_M0:    begin dig_ready = 1'b1; digit_idx = 2'd3; end
      default: ;
    endcase
  end

  assign busy   = (state != S_H1);
  assign accept = dig_valid && dig_ready;

  // Each digit is judged against the digits already stored, so an entry fails at the first bad digit
  always_comb begin
    dig_bad = (dig_in > MAX_BCD);
    unique case (state)
      S_H1: if (dig_in > MAX_HOUR_TENS) dig_bad = 1'b1;
      S_H0: begin
        if (ht == MAX_HOUR_TENS && dig_in > MAX_HOUR_UNITS_TOP) dig_bad = 1'b1;
        if (HOUR12 && ht == 4'd0 && dig_in == 4'd0) dig_bad = 1'b1;
      end
      S_M1: if (dig_in > MAX_MIN_TENS) dig_bad = 1'b1;
      default: ;
    endcase
  end

  // One converter shared by both conversion states
  assign conv_tens  = (state == S_CONV_M) ? mt : ht;
  assign conv_units = (state == S_CONV_M) ? mu : hu;

  bcd2bin_mul10 u_mul10 (
    .tens  (conv_tens),
    .units (conv_units),
    .bin   (conv_bin)
  );

  assign unused_conv_msb = conv_bin[6];

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state      <= S_H1;
      ht         <= '0;
      hu         <= '0;
      mt         <= '0;
      mu         <= '0;
      tmo        <= '0;
      hour_q     <= '0;
      min_q      <= '0;
      hour_bin   <= '0;
      min_bin    <= '0;
      load_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      if (abort) begin
        state <= S_H1;
        ht    <= '0;
        hu    <= '0;
        mt    <= '0;
        mu    <= '0;
        tmo   <= '0;
      end else begin
        unique case (state)
          S_H1, S_H0, S_M1, S_M0: begin
            if (accept) begin
              tmo <= '0;
              if (dig_bad) begin
                err_pulse <= 1'b1;
                state     <= S_H1;
                ht        <= '0;
                hu        <= '0;
                mt        <= '0;
                mu        <= '0;
              end else begin
                unique case (state)
                  S_H1:    begin ht <= dig_in; state <= S_H0; end
                  S_H0:    begin hu <= dig_in; state <= S_M1; end
                  S_M1:    begin mt <= dig_in; state <= S_M0; end
                  default: begin mu <= dig_in; state <= S_CONV_H; end
                endcase
              end
            end else if (state != S_H1) begin
              if (tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
                err_pulse <= 1'b1;
                state     <= S_H1;
                tmo       <= '0;
                ht        <= '0;
                hu        <= '0;
                mt        <= '0;
                mu        <= '0;
              end else begin
                tmo <= tmo + 1'b1;
              end
            end
          end
          S_CONV_H: begin
            hour_q <= conv_bin[4:0];
            state  <= S_CONV_M;
          end
          S_CONV_M: begin
            min_q <= conv_bin[5:0];
            state <= S_DONE;
          end
          S_DONE: begin
            hour_bin   <= hour_q;
            min_bin    <= min_q;
            load_pulse <= 1'b1;
            state      <= S_H1;
            ht         <= '0;
            hu         <= '0;
            mt         <= '0;
            mu         <= '0;
          end
          default: state <= S_H1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_load.sv
// Bench for bcd_time_load: directed cases plus random entries against a time-set reference model.
// Compile with HOUR12_EN to exercise the 12-hour build.
module tb_bcd_time_load;

  localparam int unsigned TMO = 20;

  logic       clk = 1'b0;
  logic       reset_;
  logic       dig_valid;
  logic [3:0] dig_in;
  logic       abort;
  logic       dig_ready;
  logic [1:0] digit_idx;
  logic       busy;
  logic [4:0] hour_bin;
  logic [5:0] min_bin;
  logic       load_pulse;
  logic       err_pulse;

  int passed = 0;
  int total  = 0;
  int exp_hour = 0;
  int exp_min  = 0;

  bcd_time_load #(.TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .reset_     (reset_),
    .dig_valid  (dig_valid),
    .dig_in     (dig_in),
    .abort      (abort),
    .dig_ready  (dig_ready),
    .digit_idx  (digit_idx),
    .busy       (busy),
    .hour_bin   (hour_bin),
    .min_bin    (min_bin),
    .load_pulse (load_pulse),
    .err_pulse  (err_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic bit hour_ok(input int h);
`ifdef HOUR12_EN
    return (h >= 1) && (h <= 12);
`else
    return (h >= 0) && (h <= 23);
`endif
  endfunction

  // True if the first k digits can still be completed into some legal hh:mm
  function automatic bit prefix_ok(input int d[4], input int k);
    for (int h = 0; h < 24; h++) begin
      for (int m = 0; m < 60; m++) begin
        int t[4];
        bit match;
        t[0] = h / 10; t[1] = h % 10; t[2] = m / 10; t[3] = m % 10;
        match = hour_ok(h);
        for (int i = 0; i < k; i++) if (t[i] != d[i]) match = 1'b0;
        if (match) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check_outputs_held(input string tag);
    check({tag, "_hour"}, 32'(hour_bin), exp_hour);
    check({tag, "_min"}, 32'(min_bin), exp_min);
  endtask

  // Drives one digit in the next cycle; caller handles expectations afterwards
  task automatic push(input int d, input bit with_abort);
    dig_valid = 1'b1;
    dig_in    = 4'(d);
    abort     = with_abort;
    tick();
    dig_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic run_entry(input int d0, input int d1, input int d2, input int d3,
                           input int max_gap);
    int d[4];
    int rej;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    rej = 4;
    for (int k = 1; k <= 4; k++) begin
      if (!prefix_ok(d, k)) begin
        rej = k - 1;
        break;
      end
    end
    for (int k = 0; k < 4; k++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_no_err", 32'(err_pulse), 0);
      end
      check("ready", 32'(dig_ready), 1);
      check("idx", 32'(digit_idx), k);
      push(d[k], 1'b0);
      if (k == rej) begin
        check("rej_err", 32'(err_pulse), 1);
        check("rej_idx", 32'(digit_idx), 0);
        check("rej_busy", 32'(busy), 0);
        check("rej_load", 32'(load_pulse), 0);
        check_outputs_held("rej");
        tick();
        check("rej_err_once", 32'(err_pulse), 0);
        return;
      end
      check("acc_busy", 32'(busy), 1);
      check("acc_no_err", 32'(err_pulse), 0);
    end
    check("conv_ready", 32'(dig_ready), 0);
    tick();
    check("lat1_load", 32'(load_pulse), 0);
    tick();
    check("lat2_load", 32'(load_pulse), 0);
    tick();
    exp_hour = d[0] * 10 + d[1];
    exp_min  = d[2] * 10 + d[3];
    check("load", 32'(load_pulse), 1);
    check_outputs_held("load");
    tick();
    check("load_once", 32'(load_pulse), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int errs;
    int loads;
    reset_    = 1'b0;
    dig_valid = 1'b0;
    dig_in    = 4'd0;
    abort     = 1'b0;
    tick();
    tick();
    check("rst_hour", 32'(hour_bin), 0);
    check("rst_min", 32'(min_bin), 0);
    check("rst_load", 32'(load_pulse), 0);
    check("rst_err", 32'(err_pulse), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(dig_ready), 1);
    check("rst_idx", 32'(digit_idx), 0);
    reset_ = 1'b1;
    tick();

`ifdef HOUR12_EN
    run_entry(0, 0, 1, 0, 0);
    check("h12_00_rej", 32'(hour_bin), 0);
    run_entry(1, 2, 0, 0, 0);
    check("h12_hour12", 32'(hour_bin), 12);
    check("h12_min0", 32'(min_bin), 0);
    run_entry(1, 3, 0, 0, 0);
    run_entry(2, 0, 0, 0, 0);
    run_entry(0, 7, 0, 5, 1);
`else
    run_entry(2, 3, 5, 9, 0);
    check("h24_hour23", 32'(hour_bin), 23);
    check("h24_min59", 32'(min_bin), 59);
    run_entry(2, 4, 0, 0, 0);
    run_entry(0, 7, 0, 5, 0);
    check("h24_hour7", 32'(hour_bin), 7);
    check("h24_min5", 32'(min_bin), 5);
    run_entry(1, 2, 6, 0, 0);
    run_entry(0, 0, 0, 0, 0);
`endif
    run_entry(10, 0, 0, 0, 0);

    // Timeout after two digits
    push(1, 1'b0);
    push(0, 1'b0);
    errs  = 0;
    loads = 0;
    for (int i = 0; i < int'(TMO); i++) begin
      tick();
      errs  += int'(err_pulse);
      loads += int'(load_pulse);
    end
    check("tmo_err_count", errs, 1);
    check("tmo_no_load", loads, 0);
    check("tmo_idx", 32'(digit_idx), 0);
    check("tmo_busy", 32'(busy), 0);
    check_outputs_held("tmo");

    // Abort together with the minute-units digit
    push(1, 1'b0);
    push(1, 1'b0);
    push(3, 1'b0);
    push(4, 1'b1);
    errs  = 0;
    loads = 0;
    for (int i = 0; i < 5; i++) begin
      errs  += int'(err_pulse);
      loads += int'(load_pulse);
      tick();
    end
    check("abort_m0_err", errs, 0);
    check("abort_m0_load", loads, 0);
    check("abort_m0_busy", 32'(busy), 0);
    check_outputs_held("abort_m0");

    // Abort while converting minutes
    push(1, 1'b0);
    push(0, 1'b0);
    push(4, 1'b0);
    push(2, 1'b0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    errs  = 0;
    loads = 0;
    for (int i = 0; i < 5; i++) begin
      errs  += int'(err_pulse);
      loads += int'(load_pulse);
      tick();
    end
    check("abort_cm_err", errs, 0);
    check("abort_cm_load", loads, 0);
    check("abort_cm_idx", 32'(digit_idx), 0);
    check_outputs_held("abort_cm");

    // Random entries, mostly plausible digits with occasional non-BCD values
    for (int n = 0; n < 40; n++) begin
      int r[4];
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) r[i] = int'($urandom_range(10, 15));
        else r[i] = int'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 3) != 0) r[0] = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) r[2] = int'($urandom_range(0, 5));
      run_entry(r[0], r[1], r[2], r[3], 3);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

endmodule
